// File: rtl/divider_param_if.sv
// Request/result bundle for divider_param: operands and mode in, quotient,
// remainder, status flags and handshake out.
interface divider_param_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             signed_mode;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             in_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             ready;
  logic             div_zero;
  logic             overflow;

  modport master (
    output valid, signed_mode, DIVIDEND, DIVISOR,
    input  in_ready, Q, R, ready, div_zero, overflow
  );

  modport slave (
    input  valid, signed_mode, DIVIDEND, DIVISOR,
    output in_ready, Q, R, ready, div_zero, overflow
  );
endinterface

// File: rtl/divider_param.sv
// Iterative radix-2 restoring divider, WIDTH-bit operands, signed or unsigned
// per operation. One quotient bit per cycle; results are registered on the
// edge that retires the last bit, so the FIX cycle both presents the result
// (ready=1) and can accept the next request.
module divider_param #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             async_rst_n,
  divider_param_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_in_ready;
  logic               w_ready;
  logic               w_accept;
  logic               w_last;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_dd;
  logic               r_sign_dv;
  logic [WIDTH-1:0]   r_quo;   // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0]   r_dv;    // divisor magnitude
  logic [WIDTH-1:0]   r_rem;   // partial remainder
  logic               r_dz;
  logic               r_ov;

  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic               r_dz_o;
  logic               r_ov_o;

  logic               w_sign_dd;
  logic               w_sign_dv;
  logic [WIDTH-1:0]   w_mag_dd;
  logic [WIDTH-1:0]   w_mag_dv;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_qmag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // Operand conditioning at accept time.
  assign w_sign_dd = bus.signed_mode & bus.DIVIDEND[WIDTH-1];
  assign w_sign_dv = bus.signed_mode & bus.DIVISOR[WIDTH-1];
  assign w_mag_dd  = w_sign_dd ? -bus.DIVIDEND : bus.DIVIDEND;
  assign w_mag_dv  = w_sign_dv ? -bus.DIVISOR  : bus.DIVISOR;

  // One restoring step; rem < divisor keeps the trial within WIDTH+1 bits.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dv});
  assign w_diff     = w_trial[WIDTH-1:0] - r_dv;
  assign w_rem_next = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_qmag     = {r_quo[WIDTH-2:0], w_ge};

  // Sign fix-up is folded into the last CALC edge so the result is already
  // registered while FIX pulses ready. Divide-by-zero forces an all-ones
  // quotient; the restoring datapath already returns the dividend as R.
  assign w_q_fix = r_dz ? '1 : ((r_sign_dd ^ r_sign_dv) ? -w_qmag : w_qmag);
  assign w_r_fix = r_sign_dd ? -w_rem_next : w_rem_next;

  // State register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_ready    = 1'b0;
    w_last     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.valid) w_next = S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last = 1'b1;
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_in_ready = 1'b1;
        w_ready    = 1'b1;
        w_next     = bus.valid ? S_CALC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = bus.valid & w_in_ready;

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_cnt     <= '0;
      r_sign_dd <= 1'b0;
      r_sign_dv <= 1'b0;
      r_quo     <= '0;
      r_dv      <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
      r_ov      <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_dz_o    <= 1'b0;
      r_ov_o    <= 1'b0;
    end else if (w_accept) begin
      r_sign_dd <= w_sign_dd;
      r_sign_dv <= w_sign_dv;
      r_quo     <= w_mag_dd;
      r_dv      <= w_mag_dv;
      r_rem     <= '0;
      r_cnt     <= CNT_W'(WIDTH);
      r_dz      <= (bus.DIVISOR == '0);
      r_ov      <= bus.signed_mode && (bus.DIVIDEND == {1'b1, {(WIDTH-1){1'b0}}})
                   && (bus.DIVISOR == '1);
    end else if (r_state == S_CALC) begin
      r_quo <= w_qmag;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_q    <= w_q_fix;
        r_r    <= w_r_fix;
        r_dz_o <= r_dz;
        r_ov_o <= r_ov;
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.ready    = w_ready;
  assign bus.Q        = r_q;
  assign bus.R        = r_r;
  assign bus.div_zero = r_dz_o;
  assign bus.overflow = r_ov_o;

endmodule

// File: tb/tb_divider_param.sv
// Directed bench for divider_param: a 32-bit and an 8-bit instance share
// clock and reset; each scenario task checks its own results inline.
module tb_divider_param;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  divider_param_if #(.WIDTH(32)) if32 ();
  divider_param_if #(.WIDTH(8))  if8 ();

  divider_param #(.WIDTH(32)) u_dut32 (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (if32.slave)
  );

  divider_param #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (if8.slave)
  );

  always #5 clk = ~clk;

  // Issue one request to the 8-bit DUT (called just after an edge while
  // in_ready=1); lat counts clock periods from the accept edge to ready.
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] q, output logic [7:0] r,
                      output logic dz, output logic ov, output int lat);
    if8.signed_mode = sm;
    if8.DIVIDEND    = a;
    if8.DIVISOR     = b;
    if8.valid       = 1'b1;
    @(posedge clk); #1;
    if8.valid = 1'b0;
    lat = 1;
    while (!if8.ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q = if8.Q; r = if8.R; dz = if8.div_zero; ov = if8.overflow;
  endtask

  task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    if32.signed_mode = sm;
    if32.DIVIDEND    = a;
    if32.DIVISOR     = b;
    if32.valid       = 1'b1;
    @(posedge clk); #1;
    if32.valid = 1'b0;
    lat = 1;
    while (!if32.ready && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    q = if32.Q; r = if32.R; dz = if32.div_zero; ov = if32.overflow;
  endtask

  task automatic test_reset();
    logic [37:0] exp32;
    logic [21:0] exp8;
    exp32 = {32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    exp8  = {8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
    #2;
    n_tests++;
    if ({if32.Q, if32.ready, if32.div_zero, if32.overflow, if32.in_ready, if32.R[1:0]} !== exp32) begin
      n_fail++;
      $display("FAIL reset32: Q=%h R=%h rdy=%b dz=%b ov=%b in_rdy=%b, want all zero with in_ready=1",
               if32.Q, if32.R, if32.ready, if32.div_zero, if32.overflow, if32.in_ready);
    end
    n_tests++;
    if ({if8.Q, if8.R, if8.ready, if8.div_zero, if8.overflow, if8.in_ready, 2'b00} !== exp8) begin
      n_fail++;
      $display("FAIL reset8: Q=%h R=%h rdy=%b dz=%b ov=%b in_rdy=%b, want all zero with in_ready=1",
               if8.Q, if8.R, if8.ready, if8.div_zero, if8.overflow, if8.in_ready);
    end
    #20 async_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed32();
    logic [31:0] a_v [3] = '{32'h26A5515D, 32'hD5547562, 32'hD1D54D1D};
    logic [31:0] b_v [3] = '{32'h000E895A, 32'h000435CA, 32'hFFFE25EA};
    logic [31:0] q_v [3] = '{32'h000002A8, 32'hFFFFF5DE, 32'h000018ED};
    logic [31:0] r_v [3] = '{32'h00087A4D, 32'hFFFD7E36, 32'hFFFE437B};
    logic [31:0] q, r;
    logic dz, ov;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run32(1'b1, a_v[i], b_v[i], q, r, dz, ov, lat);
      n_tests++;
      if ({q, r} !== {q_v[i], r_v[i]}) begin
        n_fail++;
        $display("FAIL signed32[%0d]: Q=%h R=%h, want Q=%h R=%h", i, q, r, q_v[i], r_v[i]);
      end
      n_tests++;
      if ({dz, ov} !== 2'b00 || lat !== 33) begin
        n_fail++;
        $display("FAIL signed32_flags_lat[%0d]: dz=%b ov=%b lat=%0d, want 0 0 33", i, dz, ov, lat);
      end
    end
  endtask

  task automatic test_mode8();
    logic [7:0] q, r;
    logic dz, ov;
    int lat;
    logic       m_v [2] = '{1'b0, 1'b1};
    logic [7:0] q_v [2] = '{8'h1C, 8'hF8};
    logic [7:0] r_v [2] = '{8'h04, 8'h00};
    for (int i = 0; i < 2; i++) begin
      run8(m_v[i], 8'hC8, 8'h07, q, r, dz, ov, lat);
      n_tests++;
      if ({q, r} !== {q_v[i], r_v[i]}) begin
        n_fail++;
        $display("FAIL mode8[%0d]: Q=%h R=%h, want Q=%h R=%h", i, q, r, q_v[i], r_v[i]);
      end
      n_tests++;
      if ({dz, ov} !== 2'b00 || lat !== 9) begin
        n_fail++;
        $display("FAIL mode8_flags_lat[%0d]: dz=%b ov=%b lat=%0d, want 0 0 9", i, dz, ov, lat);
      end
    end
  endtask

  task automatic test_edges8();
    logic       m_v  [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
    logic [7:0] a_v  [4] = '{8'h25, 8'h9C, 8'h80, 8'h09};
    logic [7:0] b_v  [4] = '{8'h00, 8'h00, 8'hFF, 8'h02};
    logic [7:0] q_v  [4] = '{8'hFF, 8'hFF, 8'h80, 8'h04};
    logic [7:0] r_v  [4] = '{8'h25, 8'h9C, 8'h00, 8'h01};
    logic [1:0] f_v  [4] = '{2'b10, 2'b10, 2'b01, 2'b00};
    logic [7:0] q, r;
    logic dz, ov;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run8(m_v[i], a_v[i], b_v[i], q, r, dz, ov, lat);
      n_tests++;
      if ({q, r} !== {q_v[i], r_v[i]}) begin
        n_fail++;
        $display("FAIL edges8[%0d]: Q=%h R=%h, want Q=%h R=%h", i, q, r, q_v[i], r_v[i]);
      end
      n_tests++;
      if ({dz, ov} !== f_v[i] || lat !== 9) begin
        n_fail++;
        $display("FAIL edges8_flags_lat[%0d]: dz,ov=%b%b lat=%0d, want %b lat=9", i, dz, ov, lat, f_v[i]);
      end
    end
  endtask

  // valid stays high; real operands are offered only while in_ready=1,
  // scrambled values otherwise, so a CALC-time accept would corrupt results.
  task automatic test_back_to_back();
    logic [7:0] a_v [3] = '{8'hC8, 8'h09, 8'h25};
    logic [7:0] b_v [3] = '{8'h07, 8'h02, 8'h03};
    logic [7:0] q_v [3] = '{8'h1C, 8'h04, 8'h0C};
    logic [7:0] r_v [3] = '{8'h04, 8'h01, 8'h01};
    int idx = 0, res = 0, e = 0, last = 0;
    logic acc;
    if8.signed_mode = 1'b0;
    while (res < 3 && e < 100) begin
      if (if8.in_ready && idx < 3) begin
        if8.valid = 1'b1; if8.DIVIDEND = a_v[idx]; if8.DIVISOR = b_v[idx]; acc = 1'b1;
      end else begin
        if8.valid = (idx < 3); if8.DIVIDEND = 8'($urandom); if8.DIVISOR = 8'($urandom); acc = 1'b0;
      end
      @(posedge clk); #1;
      e++;
      if (acc) idx++;
      if (if8.ready) begin
        n_tests++;
        if ({if8.Q, if8.R} !== {q_v[res], r_v[res]}) begin
          n_fail++;
          $display("FAIL b2b[%0d]: Q=%h R=%h, want Q=%h R=%h", res, if8.Q, if8.R, q_v[res], r_v[res]);
        end
        n_tests++;
        if (if8.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: in_ready=%b during ready, want 1", res, if8.in_ready);
        end
        if (res > 0) begin
          n_tests++;
          if (e - last !== 9) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: %0d cycles between ready pulses, want 9", res, e - last);
          end
        end
        last = e;
        res++;
      end
    end
    if8.valid = 1'b0;
    n_tests++;
    if (res !== 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d results seen, want 3", res);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] q, r;
    logic dz, ov, saw;
    int lat;
    if32.signed_mode = 1'b1; if32.DIVIDEND = 32'h12345678; if32.DIVISOR = 32'h00000123;
    if32.valid = 1'b1;
    @(posedge clk); #1;
    if32.valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 async_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if32.Q, if32.R, if32.ready, if32.div_zero, if32.overflow, if32.in_ready} !== {64'h0, 4'b0001}) begin
      n_fail++;
      $display("FAIL async_reset32: Q=%h R=%h rdy=%b dz=%b ov=%b in_rdy=%b, want zeros and in_ready=1",
               if32.Q, if32.R, if32.ready, if32.div_zero, if32.overflow, if32.in_ready);
    end
    n_tests++;
    if ({if8.Q, if8.R, if8.ready, if8.in_ready} !== {16'h0, 2'b01}) begin
      n_fail++;
      $display("FAIL async_reset8: Q=%h R=%h rdy=%b in_rdy=%b, want 0 0 0 1",
               if8.Q, if8.R, if8.ready, if8.in_ready);
    end
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if32.ready) saw = 1'b1;
      if (i == 4) async_rst_n = 1'b1;
    end
    n_tests++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_no_ready: ready=%b seen after abort, want 0", saw);
    end
    run32(1'b1, 32'h26A5515D, 32'h000E895A, q, r, dz, ov, lat);
    n_tests++;
    if ({q, r, dz, ov} !== {32'h000002A8, 32'h00087A4D, 2'b00} || lat !== 33) begin
      n_fail++;
      $display("FAIL post_reset_op: Q=%h R=%h dz=%b ov=%b lat=%0d, want 000002a8 00087a4d 0 0 33",
               q, r, dz, ov, lat);
    end
  endtask

  initial begin
    if32.valid = 1'b0; if32.signed_mode = 1'b0; if32.DIVIDEND = '0; if32.DIVISOR = '0;
    if8.valid  = 1'b0; if8.signed_mode  = 1'b0; if8.DIVIDEND  = '0; if8.DIVISOR  = '0;
    test_reset();
    test_signed32();
    test_mode8();
    test_edges8();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
